// File: rtl/xrs_wb_pkg.sv
// Shared encodings for the xrs writeback arbiter: load size codes, grant
// identifiers, the extension-strobe bundle and the strobe selection helper.
package xrs_wb_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  typedef struct packed {
    logic rsx8;
    logic rsx16;
    logic rsx32;
    logic rsx64;
    logic rzx8;
    logic rzx16;
    logic rzx32;
  } strobe_t;

  localparam strobe_t STROBE_NONE = 7'b000_0000;

  // An unsigned dword needs no extension, so it shares rsx64 with signed dword and the ALU.
  function automatic strobe_t strobe_map(input grant_e src, input logic [1:0] size,
                                         input logic is_unsigned, input logic [4:0] rd);
    strobe_t s;
    s = STROBE_NONE;
    if (rd == 5'd0) begin
      s = STROBE_NONE;
    end else if (src == GRANT_ALU) begin
      s.rsx64 = 1'b1;
    end else begin
      case (size)
        SIZE_B:  if (is_unsigned) s.rzx8  = 1'b1; else s.rsx8  = 1'b1;
        SIZE_H:  if (is_unsigned) s.rzx16 = 1'b1; else s.rsx16 = 1'b1;
        SIZE_W:  if (is_unsigned) s.rzx32 = 1'b1; else s.rsx32 = 1'b1;
        SIZE_D:  s.rsx64 = 1'b1;
        default: s = STROBE_NONE;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/xrs_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU requesters, the arbiter and xrs.
// Scoreboard signals exist only when XRS_WB_SCOREBOARD_EN is defined.
interface xrs_wb_arbiter_if;

  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [63:0] alu_dat_i;

  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [63:0] lsu_dat_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_unsigned_i;

  logic [4:0]  rd_o;
  logic [63:0] rdat_o;
  logic        rsx8_o;
  logic        rsx16_o;
  logic        rsx32_o;
  logic        rsx64_o;
  logic        rzx8_o;
  logic        rzx16_o;
  logic        rzx32_o;

`ifdef XRS_WB_SCOREBOARD_EN
  logic        iss_valid_i;
  logic [4:0]  iss_rd_i;
  logic [4:0]  ra_i;
  logic [4:0]  rb_i;
  logic        ra_busy_o;
  logic        rb_busy_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_dat_i,
    input  lsu_valid_i, lsu_rd_i, lsu_dat_i, lsu_size_i, lsu_unsigned_i,
    output alu_ready_o, lsu_ready_o,
    output rd_o, rdat_o, rsx8_o, rsx16_o, rsx32_o, rsx64_o, rzx8_o, rzx16_o, rzx32_o,
    input  iss_valid_i, iss_rd_i, ra_i, rb_i,
    output ra_busy_o, rb_busy_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_dat_i,
    output lsu_valid_i, lsu_rd_i, lsu_dat_i, lsu_size_i, lsu_unsigned_i,
    input  alu_ready_o, lsu_ready_o,
    input  rd_o, rdat_o, rsx8_o, rsx16_o, rsx32_o, rsx64_o, rzx8_o, rzx16_o, rzx32_o,
    output iss_valid_i, iss_rd_i, ra_i, rb_i,
    input  ra_busy_o, rb_busy_o
  );
`else
  modport slave (
    input  alu_valid_i, alu_rd_i, alu_dat_i,
    input  lsu_valid_i, lsu_rd_i, lsu_dat_i, lsu_size_i, lsu_unsigned_i,
    output alu_ready_o, lsu_ready_o,
    output rd_o, rdat_o, rsx8_o, rsx16_o, rsx32_o, rsx64_o, rzx8_o, rzx16_o, rzx32_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_dat_i,
    output lsu_valid_i, lsu_rd_i, lsu_dat_i, lsu_size_i, lsu_unsigned_i,
    input  alu_ready_o, lsu_ready_o,
    input  rd_o, rdat_o, rsx8_o, rsx16_o, rsx32_o, rsx64_o, rzx8_o, rzx16_o, rzx32_o
  );
`endif

endinterface

// File: rtl/xrs_wb_scoreboard.sv
// Pending-write scoreboard for xrs: issue marks a register busy, the
// writeback strobe cycle for that register clears it (issue wins on a tie).
module xrs_wb_scoreboard (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       iss_valid_i,
  input  logic [4:0] iss_rd_i,
  input  logic       clr_valid_i,
  input  logic [4:0] clr_rd_i,
  input  logic [4:0] ra_i,
  input  logic [4:0] rb_i,
  output logic       ra_busy_o,
  output logic       rb_busy_o
);

  logic [31:0] pend_r;
  logic [31:0] set_mask_s;
  logic [31:0] clr_mask_s;
  logic [31:0] pend_nxt_s;

  // Set is OR-ed after the clear so a same-edge issue keeps the register busy; x0 never pends.
  always_comb begin
    set_mask_s = (iss_valid_i && (iss_rd_i != 5'd0)) ? (32'd1 << iss_rd_i) : 32'd0;
    clr_mask_s = clr_valid_i ? (32'd1 << clr_rd_i) : 32'd0;
    pend_nxt_s = ((pend_r & ~clr_mask_s) | set_mask_s) & ~32'd1;
  end

  // Pending vector register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_r <= 32'd0;
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  assign ra_busy_o = (ra_i != 5'd0) && pend_r[ra_i];
  assign rb_busy_o = (rb_i != 5'd0) && pend_r[rb_i];

endmodule

// File: rtl/xrs_wb_arbiter.sv
// Arbitrates ALU and LSU writebacks onto the single xrs write port with a
// one-cycle registered output. Define XRS_WB_SCOREBOARD_EN to add the pending-write scoreboard.
module xrs_wb_arbiter
  import xrs_wb_pkg::*;
#(
  parameter int PRIORITY_RR = 1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  xrs_wb_arbiter_if.slave bus
);

  grant_e      last_grant_r;
  logic        alu_ready_s;
  logic        lsu_ready_s;
  logic [4:0]  sel_rd_s;
  logic [63:0] sel_dat_s;
  strobe_t     sel_stb_s;

  logic [4:0]  rd_r;
  logic [63:0] rdat_r;
  strobe_t     stb_r;

  // Grant: a lone requester wins at once; on conflict the rotating or fixed rule decides.
  always_comb begin
    alu_ready_s = 1'b0;
    lsu_ready_s = 1'b0;
    if (reset_i) begin
      alu_ready_s = 1'b0;
      lsu_ready_s = 1'b0;
    end else if (bus.alu_valid_i && bus.lsu_valid_i) begin
      if ((PRIORITY_RR != 0) && (last_grant_r == GRANT_LSU)) begin
        alu_ready_s = 1'b1;
      end else begin
        lsu_ready_s = 1'b1;
      end
    end else begin
      alu_ready_s = bus.alu_valid_i;
      lsu_ready_s = bus.lsu_valid_i;
    end
  end

  // Winner's write; zeros when nothing is granted so idle cycles drive a clean port.
  always_comb begin
    sel_rd_s  = 5'd0;
    sel_dat_s = 64'd0;
    sel_stb_s = STROBE_NONE;
    if (lsu_ready_s) begin
      sel_rd_s  = bus.lsu_rd_i;
      sel_dat_s = bus.lsu_dat_i;
      sel_stb_s = strobe_map(GRANT_LSU, bus.lsu_size_i, bus.lsu_unsigned_i, bus.lsu_rd_i);
    end else if (alu_ready_s) begin
      sel_rd_s  = bus.alu_rd_i;
      sel_dat_s = bus.alu_dat_i;
      sel_stb_s = strobe_map(GRANT_ALU, SIZE_D, 1'b0, bus.alu_rd_i);
    end else begin
      sel_rd_s  = 5'd0;
      sel_dat_s = 64'd0;
      sel_stb_s = STROBE_NONE;
    end
  end

  // Output register and round-robin history; history moves only on a handshake.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant_r <= GRANT_ALU;
      rd_r         <= 5'd0;
      rdat_r       <= 64'd0;
      stb_r        <= STROBE_NONE;
    end else begin
      rd_r   <= sel_rd_s;
      rdat_r <= sel_dat_s;
      stb_r  <= sel_stb_s;
      if (lsu_ready_s) begin
        last_grant_r <= GRANT_LSU;
      end else if (alu_ready_s) begin
        last_grant_r <= GRANT_ALU;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  assign bus.alu_ready_o = alu_ready_s;
  assign bus.lsu_ready_o = lsu_ready_s;
  assign bus.rd_o        = rd_r;
  assign bus.rdat_o      = rdat_r;
  assign bus.rsx8_o      = stb_r.rsx8;
  assign bus.rsx16_o     = stb_r.rsx16;
  assign bus.rsx32_o     = stb_r.rsx32;
  assign bus.rsx64_o     = stb_r.rsx64;
  assign bus.rzx8_o      = stb_r.rzx8;
  assign bus.rzx16_o     = stb_r.rzx16;
  assign bus.rzx32_o     = stb_r.rzx32;

`ifdef XRS_WB_SCOREBOARD_EN
  logic [6:0] stb_bits_s;
  assign stb_bits_s = stb_r;

  xrs_wb_scoreboard u_scoreboard (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .iss_valid_i (bus.iss_valid_i),
    .iss_rd_i    (bus.iss_rd_i),
    .clr_valid_i (|stb_bits_s),
    .clr_rd_i    (rd_r),
    .ra_i        (bus.ra_i),
    .rb_i        (bus.rb_i),
    .ra_busy_o   (bus.ra_busy_o),
    .rb_busy_o   (bus.rb_busy_o)
  );
`endif

endmodule

// File: tb/tb_xrs_wb_arbiter.sv
// Self-checking bench for xrs_wb_arbiter: a round-robin and a fixed-priority
// instance share the same stimulus and are both checked against a grant/writeback model.
module tb_xrs_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_dat;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_dat;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  xrs_wb_arbiter_if bus_rr ();
  xrs_wb_arbiter_if bus_fp ();

  assign bus_rr.alu_valid_i    = alu_valid;
  assign bus_rr.alu_rd_i       = alu_rd;
  assign bus_rr.alu_dat_i      = alu_dat;
  assign bus_rr.lsu_valid_i    = lsu_valid;
  assign bus_rr.lsu_rd_i       = lsu_rd;
  assign bus_rr.lsu_dat_i      = lsu_dat;
  assign bus_rr.lsu_size_i     = lsu_size;
  assign bus_rr.lsu_unsigned_i = lsu_unsigned;
  assign bus_fp.alu_valid_i    = alu_valid;
  assign bus_fp.alu_rd_i       = alu_rd;
  assign bus_fp.alu_dat_i      = alu_dat;
  assign bus_fp.lsu_valid_i    = lsu_valid;
  assign bus_fp.lsu_rd_i       = lsu_rd;
  assign bus_fp.lsu_dat_i      = lsu_dat;
  assign bus_fp.lsu_size_i     = lsu_size;
  assign bus_fp.lsu_unsigned_i = lsu_unsigned;

`ifdef XRS_WB_SCOREBOARD_EN
  logic       iss_valid;
  logic [4:0] iss_rd;
  logic [4:0] ra;
  logic [4:0] rb;
  assign bus_rr.iss_valid_i = iss_valid;
  assign bus_rr.iss_rd_i    = iss_rd;
  assign bus_rr.ra_i        = ra;
  assign bus_rr.rb_i        = rb;
  assign bus_fp.iss_valid_i = iss_valid;
  assign bus_fp.iss_rd_i    = iss_rd;
  assign bus_fp.ra_i        = ra;
  assign bus_fp.rb_i        = rb;
`endif

  xrs_wb_arbiter #(.PRIORITY_RR(1)) dut_rr (.clk_i(clk), .reset_i(reset), .bus(bus_rr.slave));
  xrs_wb_arbiter #(.PRIORITY_RR(0)) dut_fp (.clk_i(clk), .reset_i(reset), .bus(bus_fp.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs, index 0 = round-robin, 1 = fixed priority; strobes as {rsx8,rsx16,rsx32,rsx64,rzx8,rzx16,rzx32}
  logic        ar_s [2];
  logic        lr_s [2];
  logic [4:0]  rd_s [2];
  logic [63:0] dat_s[2];
  logic [6:0]  stb_s[2];
  assign ar_s[0]  = bus_rr.alu_ready_o;
  assign lr_s[0]  = bus_rr.lsu_ready_o;
  assign rd_s[0]  = bus_rr.rd_o;
  assign dat_s[0] = bus_rr.rdat_o;
  assign stb_s[0] = {bus_rr.rsx8_o, bus_rr.rsx16_o, bus_rr.rsx32_o, bus_rr.rsx64_o,
                     bus_rr.rzx8_o, bus_rr.rzx16_o, bus_rr.rzx32_o};
  assign ar_s[1]  = bus_fp.alu_ready_o;
  assign lr_s[1]  = bus_fp.lsu_ready_o;
  assign rd_s[1]  = bus_fp.rd_o;
  assign dat_s[1] = bus_fp.rdat_o;
  assign stb_s[1] = {bus_fp.rsx8_o, bus_fp.rsx16_o, bus_fp.rsx32_o, bus_fp.rsx64_o,
                     bus_fp.rzx8_o, bus_fp.rzx16_o, bus_fp.rzx32_o};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Strobe required by width/signedness: log2(bytes) picks the slot; dword and ALU always rsx64.
  function automatic logic [6:0] exp_stb(input bit is_lsu, input logic [1:0] sz,
                                         input logic uns, input logic [4:0] rd);
    logic [6:0] one;
    int pos;
    one = 7'd1;
    if (rd == 5'd0) return 7'd0;
    if (!is_lsu || sz == 2'd3) return 7'b0001000;
    pos = uns ? (2 - int'(sz)) : (6 - int'(sz));
    return one << pos;
  endfunction

  // What xrs would store for a given strobe and raw data.
  function automatic logic [63:0] xrs_val(input logic [6:0] s, input logic [63:0] d);
    case (s)
      7'b1000000: return {{56{d[7]}},  d[7:0]};
      7'b0100000: return {{48{d[15]}}, d[15:0]};
      7'b0010000: return {{32{d[31]}}, d[31:0]};
      7'b0001000: return d;
      7'b0000100: return {56'd0, d[7:0]};
      7'b0000010: return {48'd0, d[15:0]};
      7'b0000001: return {32'd0, d[31:0]};
      default:    return 64'd0;
    endcase
  endfunction

  // Model state: expected registered write and who won last (0 ALU, 1 LSU)
  int          last_w[2] = '{0, 0};
  logic [4:0]  e_rd [2]  = '{5'd0, 5'd0};
  logic [63:0] e_dat[2]  = '{64'd0, 64'd0};
  logic [6:0]  e_stb[2]  = '{7'd0, 7'd0};
  int          glog_rr[$];
  int          glog_fp[$];

  // Compare process: check this cycle's outputs, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int win;
        win = -1;
        if (!reset) begin
          if (alu_valid && lsu_valid) win = (k == 1) ? 1 : (1 - last_w[k]);
          else if (lsu_valid)         win = 1;
          else if (alu_valid)         win = 0;
        end
        chk($sformatf("alu_ready[%0d]", k), 64'(ar_s[k]), 64'(win == 0));
        chk($sformatf("lsu_ready[%0d]", k), 64'(lr_s[k]), 64'(win == 1));
        chk($sformatf("rd_o[%0d]", k),      64'(rd_s[k]), 64'(e_rd[k]));
        chk($sformatf("rdat_o[%0d]", k),    dat_s[k],     e_dat[k]);
        chk($sformatf("strobes[%0d]", k),   64'(stb_s[k]), 64'(e_stb[k]));
        if (reset) begin
          e_rd[k] = 5'd0; e_dat[k] = 64'd0; e_stb[k] = 7'd0; last_w[k] = 0;
        end else if (win == 1) begin
          e_rd[k] = lsu_rd; e_dat[k] = lsu_dat;
          e_stb[k] = exp_stb(1'b1, lsu_size, lsu_unsigned, lsu_rd);
          last_w[k] = 1;
        end else if (win == 0) begin
          e_rd[k] = alu_rd; e_dat[k] = alu_dat;
          e_stb[k] = exp_stb(1'b0, 2'd3, 1'b0, alu_rd);
          last_w[k] = 0;
        end else begin
          e_rd[k] = 5'd0; e_dat[k] = 64'd0; e_stb[k] = 7'd0;
        end
        if (win >= 0) begin
          if (k == 0) glog_rr.push_back(win);
          else        glog_fp.push_back(win);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_rr[4] = '{1, 0, 1, 0};

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_dat = 64'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_dat = 64'd0; lsu_size = 2'd0; lsu_unsigned = 1'b0;
`ifdef XRS_WB_SCOREBOARD_EN
    iss_valid = 1'b0; iss_rd = 5'd0; ra = 5'd0; rb = 5'd0;
`endif
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_rd", 64'(rd_s[0]), 64'd0);
    chk("reset_strobes", 64'(stb_s[0]), 64'd0);

    // ALU alone, same-cycle grant, rsx64 next cycle
    alu_valid = 1'b1; alu_rd = 5'd1; alu_dat = 64'h1122334455667788;
    @(negedge clk);
    chk("t1_alu_ready", 64'(ar_s[0]), 64'd1);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("t1_rd", 64'(rd_s[0]), 64'd1);
    chk("t1_rdat", dat_s[0], 64'h1122334455667788);
    chk("t1_strobe", 64'(stb_s[0]), 64'h08);

    // LSU signed byte then unsigned half, back to back
    lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_dat = 64'h80; lsu_size = 2'd0; lsu_unsigned = 1'b0;
    tick();
    lsu_rd = 5'd2; lsu_dat = 64'hFFFF; lsu_size = 2'd1; lsu_unsigned = 1'b1;
    @(negedge clk);
    chk("t2_sb_strobe", 64'(stb_s[0]), 64'h40);
    chk("t2_sb_xrs", xrs_val(stb_s[0], dat_s[0]), 64'hFFFFFFFFFFFFFF80);
    tick();
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("t2_uh_strobe", 64'(stb_s[0]), 64'h02);
    chk("t2_uh_xrs", xrs_val(stb_s[0], dat_s[0]), 64'h000000000000FFFF);

    // All sizes, signed and unsigned, streamed with no bubbles
    for (int i = 0; i < 8; i++) begin
      lsu_valid = 1'b1; lsu_rd = 5'(11 + i);
      lsu_dat = 64'hF0E1D2C3B4A59687 ^ {56'd0, 8'(i)};
      lsu_size = 2'(i % 4); lsu_unsigned = (i >= 4);
      tick();
    end
    lsu_valid = 1'b0;
    @(negedge clk);
    chk("t2_uw_last", xrs_val(stb_s[0], dat_s[0]), 64'hF0E1D2C3B4A59680);

    // ALU rd=0: accepted, no strobe
    alu_valid = 1'b1; alu_rd = 5'd0; alu_dat = 64'hDEAD;
    @(negedge clk);
    chk("t4_alu_ready", 64'(ar_s[0]), 64'd1);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("t4_strobes", 64'(stb_s[0]), 64'd0);

    // Handshake, then reset in the following cycle drops everything
    alu_valid = 1'b1; alu_rd = 5'd7; alu_dat = 64'h77;
    tick();
    alu_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rd", 64'(rd_s[0]), 64'd0);
    chk("t5_rdat", dat_s[0], 64'd0);
    chk("t5_strobes", 64'(stb_s[0]), 64'd0);

    // Extra conflict-free history, then reset, then four conflict cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    glog_rr.delete();
    glog_fp.delete();
    alu_valid = 1'b1; alu_rd = 5'd9;  alu_dat = 64'hAAAA_0000_0000_0009;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_dat = 64'h8000_0000_0000_0010;
    lsu_size = 2'd3; lsu_unsigned = 1'b1;
    repeat (4) tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk("t3_rr_count", 64'(glog_rr.size()), 64'd4);
    chk("t3_fp_count", 64'(glog_fp.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_rr_grant%0d", i), 64'(glog_rr[i]), 64'(exp_rr[i]));
      chk($sformatf("t3_fp_grant%0d", i), 64'(glog_fp[i]), 64'd1);
    end

    // Mixed traffic: lone requesters interleaved with conflicts
    for (int i = 0; i < 6; i++) begin
      alu_valid = (i % 3) != 1; alu_rd = 5'(20 + i); alu_dat = 64'h0123_4567_0000_0000 + 64'(i);
      lsu_valid = (i % 2) == 0; lsu_rd = 5'(i);      lsu_dat = 64'hFFFF_FFFF_8000_7F00 + 64'(i);
      lsu_size = 2'(i % 3); lsu_unsigned = (i % 2) == 1;
      tick();
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();

`ifdef XRS_WB_SCOREBOARD_EN
    // Scoreboard: busy from issue until the rd=3 strobe cycle closes; same-edge reissue wins
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    iss_valid = 1'b0; ra = 5'd3; rb = 5'd4;
    @(negedge clk);
    chk("t6_busy_after_iss", 64'(bus_rr.ra_busy_o), 64'd1);
    chk("t6_rb_idle", 64'(bus_rr.rb_busy_o), 64'd0);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_dat = 64'h3;
    tick();
    alu_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd3;
    @(negedge clk);
    chk("t6_busy_in_strobe", 64'(bus_rr.ra_busy_o), 64'd1);
    tick();
    iss_valid = 1'b0;
    @(negedge clk);
    chk("t6_set_wins", 64'(bus_rr.ra_busy_o), 64'd1);
    alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    chk("t6_busy_in_strobe2", 64'(bus_rr.ra_busy_o), 64'd1);
    tick();
    @(negedge clk);
    chk("t6_cleared", 64'(bus_rr.ra_busy_o), 64'd0);
    iss_valid = 1'b1; iss_rd = 5'd0; ra = 5'd0;
    tick();
    iss_valid = 1'b0;
    @(negedge clk);
    chk("t6_x0_never_busy", 64'(bus_fp.ra_busy_o), 64'd0);
`endif

    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
